// File: rtl/comm_pkg.sv
// Shared definitions for the inter-board single-wire link (sender and receiver).
// Holds header encoding, frame field positions and default pulse timing.
package comm_pkg;

    localparam int CNT_W      = 12;
    localparam int FRAME_BITS = 24;

    localparam int HDR_MSB  = 23;
    localparam int HDR_LSB  = 21;
    localparam int Y_MSB    = 20;
    localparam int Y_LSB    = 12;
    localparam int VX_MSB   = 11;
    localparam int VX_LSB   = 8;
    localparam int VY_MSB   = 7;
    localparam int VY_LSB   = 4;
    localparam int SIGN_BIT = 3;

    localparam int DEF_ONE_THRESH = 30;
    localparam int DEF_MIN_HIGH   = 8;
    localparam int DEF_MAX_HIGH   = 60;
    localparam int DEF_GAP_CYCLES = 2500;

    localparam int TX_T0H = 20;
    localparam int TX_T1H = 40;
    localparam int TX_T0L = 42;
    localparam int TX_T1L = 22;

    typedef enum logic [2:0] {
        HDR_NONE          = 3'd0,
        HDR_ARE_YOU_THERE = 3'd1,
        HDR_I_AM_HERE     = 3'd2,
        HDR_START_GAME    = 3'd3,
        HDR_BALL          = 3'd4,
        HDR_MISS          = 3'd5,
        HDR_I_LOST        = 3'd6,
        HDR_RSVD          = 3'd7
    } header_t;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } rx_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic header_ok(input logic [2:0] h);
        return (h != HDR_NONE) && (h != HDR_RSVD);
    endfunction

endpackage

// File: rtl/communication_receiver_decoder.sv
// Synchronizes the link pin and measures high/low run lengths.
// Emits registered rise, bit (value + width checks) and gap strobes.
module pulse_width_decoder
    import comm_pkg::*;
#(
    parameter int ONE_THRESH = DEF_ONE_THRESH,
    parameter int MIN_HIGH   = DEF_MIN_HIGH,
    parameter int MAX_HIGH   = DEF_MAX_HIGH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic neo_in,
    output logic rise,
    output logic bit_valid,
    output logic bit_value,
    output logic width_error,
    output logic long_high,
    output logic gap
);

    localparam logic [CNT_W-1:0] ONE_T = CNT_W'(ONE_THRESH);
    localparam logic [CNT_W-1:0] MIN_T = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] GAP_T = CNT_W'(GAP_CYCLES - 1);

    logic             sync1;
    logic             line;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            line  <= 1'b0;
        end else begin
            sync1 <= neo_in;
            line  <= sync1;
        end
    end

    // Saturating run-length counters for the current high and low levels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            high_cnt <= '0;
            low_cnt  <= '0;
        end else if (line) begin
            high_cnt <= sat_inc(high_cnt);
            low_cnt  <= '0;
        end else begin
            high_cnt <= '0;
            low_cnt  <= sat_inc(low_cnt);
        end
    end

    // Edge and gap strobes; a falling edge carries the finished high width.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rise        <= 1'b0;
            bit_valid   <= 1'b0;
            bit_value   <= 1'b0;
            width_error <= 1'b0;
            long_high   <= 1'b0;
            gap         <= 1'b0;
        end else begin
            rise        <= line && (high_cnt == '0);
            bit_valid   <= !line && (high_cnt != '0);
            bit_value   <= high_cnt >= ONE_T;
            width_error <= (high_cnt < MIN_T) || (high_cnt > MAX_T);
            long_high   <= high_cnt > MAX_T;
            gap         <= !line && (low_cnt == GAP_T);
        end
    end

endmodule

// File: rtl/communication_receiver.sv
// Receive side of the inter-board link: frame FSM, validation, handshake.
// Optional COMM_RX_ERROR_COUNT_EN adds a saturating error_count output.
module communication_receiver
    import comm_pkg::*;
#(
    parameter int ONE_THRESH = DEF_ONE_THRESH,
    parameter int MIN_HIGH   = DEF_MIN_HIGH,
    parameter int MAX_HIGH   = DEF_MAX_HIGH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       NEO_IN,
    output logic       message_valid,
    input  logic       message_taken,
    output logic [2:0] header_rx,
    output logic [8:0] ball_y_rx,
    output logic [3:0] velocity_x_rx,
    output logic [3:0] velocity_y_rx,
    output logic       sign_y_rx,
    output logic       ball_message_rx,
    output logic       are_you_there_rx,
    output logic       I_am_here_rx,
    output logic       start_game_rx,
    output logic       miss_message_rx,
    output logic       I_lost_rx,
    output logic       frame_error
`ifdef COMM_RX_ERROR_COUNT_EN
    ,
    output logic [7:0] error_count
`endif
);

    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_BITS);

    logic rise, bit_valid, bit_value, width_error, long_high, gap;

    rx_state_t        state_q, state_d;
    logic [23:0]      shift_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             err_q;

    logic frame_ok, eval, accept, load, drop, start, shift_en;

    pulse_width_decoder #(
        .ONE_THRESH (ONE_THRESH),
        .MIN_HIGH   (MIN_HIGH),
        .MAX_HIGH   (MAX_HIGH),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_decoder (
        .clock       (clock),
        .reset       (reset),
        .neo_in      (NEO_IN),
        .rise        (rise),
        .bit_valid   (bit_valid),
        .bit_value   (bit_value),
        .width_error (width_error),
        .long_high   (long_high),
        .gap         (gap)
    );

    // Frame state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_HUNT;
        else       state_q <= state_d;
    end

    // Frame state transitions; an over-long high resynchronizes via HUNT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HUNT: if (gap) state_d = ST_IDLE;
            ST_IDLE: if (rise) state_d = ST_HIGH;
            ST_HIGH: if (bit_valid) state_d = long_high ? ST_HUNT : ST_LOW;
            ST_LOW: begin
                if (rise)     state_d = ST_HIGH;
                else if (gap) state_d = ST_IDLE;
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // Frame evaluation, accept/drop decisions and shift control.
    always_comb begin
        frame_ok = (bit_cnt == FRAME_LEN) && !err_q
                   && header_ok(shift_q[HDR_MSB:HDR_LSB]);
        eval     = (state_q == ST_LOW) && gap;
        accept   = eval && frame_ok;
        load     = accept && (!message_valid || message_taken);
        start    = (state_q == ST_IDLE) && rise;
        shift_en = (state_q == ST_HIGH) && bit_valid && !long_high;
        drop     = (eval && !frame_ok)
                   || ((state_q == ST_HIGH) && bit_valid && long_high)
                   || (accept && message_valid && !message_taken);
    end

    // Shift register, bit counter and sticky width-error flag for a frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
            err_q   <= 1'b0;
        end else if (start) begin
            bit_cnt <= '0;
            err_q   <= 1'b0;
        end else if (shift_en) begin
            shift_q <= {shift_q[22:0], bit_value};
            bit_cnt <= sat_inc(bit_cnt);
            if (width_error) err_q <= 1'b1;
        end
    end

    // Held message and valid/taken handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            message_valid <= 1'b0;
            header_rx     <= '0;
            ball_y_rx     <= '0;
            velocity_x_rx <= '0;
            velocity_y_rx <= '0;
            sign_y_rx     <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            frame_error <= drop;
            if (load) begin
                message_valid <= 1'b1;
                header_rx     <= shift_q[HDR_MSB:HDR_LSB];
                ball_y_rx     <= shift_q[Y_MSB:Y_LSB];
                velocity_x_rx <= shift_q[VX_MSB:VX_LSB];
                velocity_y_rx <= shift_q[VY_MSB:VY_LSB];
                sign_y_rx     <= shift_q[SIGN_BIT];
            end else if (message_valid && message_taken) begin
                message_valid <= 1'b0;
            end
        end
    end

`ifdef COMM_RX_ERROR_COUNT_EN
    // Saturating count of dropped frames.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                           error_count <= '0;
        else if (frame_error && !(&error_count)) error_count <= error_count + 8'd1;
    end
`endif

    assign ball_message_rx  = message_valid && (header_rx == HDR_BALL);
    assign are_you_there_rx = message_valid && (header_rx == HDR_ARE_YOU_THERE);
    assign I_am_here_rx     = message_valid && (header_rx == HDR_I_AM_HERE);
    assign start_game_rx    = message_valid && (header_rx == HDR_START_GAME);
    assign miss_message_rx  = message_valid && (header_rx == HDR_MISS);
    assign I_lost_rx        = message_valid && (header_rx == HDR_I_LOST);

endmodule
